// File: rtl/adc_fifo_unpacker.sv
// Unpacks 256-bit ADC FIFO words (17 x 15-bit samples + pad bit) into a per-channel valid/ready stream.
// Optional pad-bit checking is enabled by defining ADC_UNPACK_PADCHK_EN.
module adc_fifo_unpacker #(
    parameter int unsigned NUM_CH          = 17,
    parameter int unsigned SAMPLE_W        = 15,
    parameter int unsigned WORDS_PER_FRAME = 1024,
    parameter int unsigned FCNT_W          = 16,
    localparam int unsigned DATA_W         = 256,
    localparam int unsigned CH_W           = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_i,
    input  logic                fifo_empty_i,
    input  logic                fifo_valid_i,
    input  logic [DATA_W-1:0]   fifo_data_i,
    output logic                fifo_rd_en_o,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic [CH_W-1:0]     ch_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                word_last_o,
    output logic                frame_last_o,
    output logic [FCNT_W-1:0]   frame_cnt_o,
    output logic                pad_err_o
);

    localparam int unsigned HOLD_W  = NUM_CH * SAMPLE_W;
    localparam int unsigned LAST_CH = NUM_CH - 1;
    localparam int unsigned WIDX_W  = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t                           state, next_state;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]  hold, hold_nxt;
    logic [WIDX_W-1:0]                word_idx, word_idx_nxt;
    logic                             rd_en_nxt, valid_nxt, word_last_nxt, frame_last_nxt, pad_err_nxt;
    logic [SAMPLE_W-1:0]              sample_nxt;
    logic [CH_W-1:0]                  ch_nxt, ch_inc;
    logic [FCNT_W-1:0]                frame_cnt_nxt;
    logic                             fetch, last_word;

    assign fetch     = enable_i && !fifo_empty_i;
    assign last_word = (word_idx == WIDX_W'(WORDS_PER_FRAME - 1));
    assign ch_inc    = ch_o + CH_W'(1);

`ifndef ADC_UNPACK_PADCHK_EN
    logic unused_pad;
    assign unused_pad = fifo_data_i[DATA_W-1];
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        next_state     = state;
        rd_en_nxt      = 1'b0;
        valid_nxt      = valid_o;
        sample_nxt     = sample_o;
        ch_nxt         = ch_o;
        word_last_nxt  = word_last_o;
        frame_last_nxt = frame_last_o;
        hold_nxt       = hold;
        word_idx_nxt   = word_idx;
        frame_cnt_nxt  = frame_cnt_o;
        pad_err_nxt    = pad_err_o;
        case (state)
            IDLE: begin
                if (fetch) begin
                    rd_en_nxt  = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (fifo_valid_i) begin
                    hold_nxt       = fifo_data_i[HOLD_W-1:0];
                    next_state     = DRAIN;
                    valid_nxt      = 1'b1;
                    ch_nxt         = '0;
                    sample_nxt     = fifo_data_i[SAMPLE_W-1:0];
                    word_last_nxt  = 1'b0;
                    frame_last_nxt = 1'b0;
`ifdef ADC_UNPACK_PADCHK_EN
                    pad_err_nxt    = pad_err_o | fifo_data_i[DATA_W-1];
`endif
                end
            end
            DRAIN: begin
                if (ready_i) begin
                    if (ch_o == CH_W'(LAST_CH)) begin
                        valid_nxt      = 1'b0;
                        word_last_nxt  = 1'b0;
                        frame_last_nxt = 1'b0;
                        if (last_word) begin
                            word_idx_nxt  = '0;
                            frame_cnt_nxt = frame_cnt_o + FCNT_W'(1);
                        end else begin
                            word_idx_nxt  = word_idx + WIDX_W'(1);
                        end
                        // Back-to-back fetch overlaps the next read with the final beat.
                        if (fetch) begin
                            rd_en_nxt  = 1'b1;
                            next_state = WAIT;
                        end else begin
                            next_state = IDLE;
                        end
                    end else begin
                        ch_nxt         = ch_inc;
                        sample_nxt     = hold[ch_inc];
                        word_last_nxt  = (ch_inc == CH_W'(LAST_CH));
                        frame_last_nxt = (ch_inc == CH_W'(LAST_CH)) && last_word;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hold         <= '0;
            word_idx     <= '0;
            fifo_rd_en_o <= 1'b0;
            valid_o      <= 1'b0;
            sample_o     <= '0;
            ch_o         <= '0;
            word_last_o  <= 1'b0;
            frame_last_o <= 1'b0;
            frame_cnt_o  <= '0;
            pad_err_o    <= 1'b0;
        end else begin
            state        <= next_state;
            hold         <= hold_nxt;
            word_idx     <= word_idx_nxt;
            fifo_rd_en_o <= rd_en_nxt;
            valid_o      <= valid_nxt;
            sample_o     <= sample_nxt;
            ch_o         <= ch_nxt;
            word_last_o  <= word_last_nxt;
            frame_last_o <= frame_last_nxt;
            frame_cnt_o  <= frame_cnt_nxt;
            pad_err_o    <= pad_err_nxt;
        end
    end

endmodule
